// File: rtl/ulas_seq.sv
// ulas_seq: multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (add/sub/logic/shifts/compares/load-upper/SRA/pass-through)
//   finish on the accept edge. MUL, DIVU and REMU run one shift-add or
//   restoring-subtract step per cycle for WIDTH cycles, then one more cycle
//   writes the results.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  request handshake; in_ready is high only when idle
//   aluop, op1, op2     operation select and operands, latched on accept
//   smt                 shift amount for SLL/SRL/SRA
//   out_valid,out_ready result handshake; results held until out_ready
//   r1, r2, UF          primary result, secondary result, flag
//   busy                high while iterative steps are being performed
module ulas_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluop,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   smt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic             UF,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIVU = 5'b10001;
    localparam logic [4:0] OP_REMU = 5'b10010;
    logic [1:0]       state;
    logic [4:0]       op;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] alu_r;
    logic             alu_uf;
    logic             iter_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    assign in_ready = (state == IDLE);
    assign iter_op  = (aluop == OP_MUL) || (aluop == OP_DIVU) || (aluop == OP_REMU);
    // Shift-add multiply: hi accumulates, lo holds the multiplier and
    // receives the product low bits as it shifts right.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    // Restoring divide: hi is the partial remainder, lo shifts the dividend
    // out at the top and the quotient bits in at the bottom. A zero divisor
    // naturally yields all-ones quotient and remainder = dividend.
    assign div_sh = {hi, lo[WIDTH-1]};
    assign div_ge = div_sh >= {1'b0, m};
    always_comb begin
        hi_n = (op == OP_MUL) ? mul_sum[WIDTH:1]
             : div_ge ? WIDTH'(div_sh - {1'b0, m}) : div_sh[WIDTH-1:0];
        lo_n = (op == OP_MUL) ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], div_ge};
    end
    always_comb begin
        alu_r  = '0;
        alu_uf = 1'b0;
        case (aluop)
            5'b00001: begin
                alu_r  = op1 + op2;
                alu_uf = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_r[WIDTH-1] != op1[WIDTH-1]);
            end
            5'b00010: begin
                alu_r  = op1 - op2;
                alu_uf = (op1[WIDTH-1] != op2[WIDTH-1]) && (alu_r[WIDTH-1] != op1[WIDTH-1]);
            end
            5'b00011: alu_r = op1 & op2;
            5'b00100: alu_r = op1 | op2;
            5'b00101: alu_r = ~op1;
            5'b00110: alu_r = op1 ^ op2;
            5'b00111: alu_r = op1 << smt;
            5'b01000: alu_r = op1 >> smt;
            5'b01001: alu_uf = op1 < op2;
            5'b01010: alu_uf = op1 > op2;
            5'b01011: alu_uf = op1 == op2;
            5'b01100: alu_uf = op1 != op2;
            5'b01101: alu_uf = op1 <= op2;
            5'b01110: alu_uf = op1 >= op2;
            5'b01111: alu_r = op2 << (WIDTH / 2);
            5'b10011: alu_r = WIDTH'($signed(op1) >>> smt);
            default:  alu_r = op2;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            hi        <= '0;
            lo        <= '0;
            m         <= '0;
            cnt       <= '0;
            r1        <= '0;
            r2        <= '0;
            UF        <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && iter_op) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        op    <= aluop;
                        m     <= op2;
                        hi    <= '0;
                        lo    <= op1;
                    end else if (in_valid) begin
                        state     <= DONE;
                        r1        <= alu_r;
                        r2        <= '0;
                        UF        <= alu_uf;
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    // busy marks the WIDTH step cycles; the following cycle
                    // (still in BUSY) publishes the results.
                    if (busy) begin
                        hi <= hi_n;
                        lo <= lo_n;
                        if (cnt == CW'(WIDTH - 1))
                            busy <= 1'b0;
                        else
                            cnt <= cnt + 1'b1;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        r1        <= (op == OP_REMU) ? hi : lo;
                        r2        <= (op == OP_REMU) ? lo : hi;
                        UF        <= (op == OP_MUL) ? (hi != '0) : (m == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ulas_seq.sv
// tb_ulas_seq: directed and randomized scoreboard bench for ulas_seq (WIDTH=32).
module tb_ulas_seq;
    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        uf;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  aluop = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  smt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        UF;
    logic        busy;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    ulas_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .op1(op1), .op2(op2), .smt(smt),
        .out_valid(out_valid), .out_ready(out_ready),
        .r1(r1), .r2(r2), .UF(UF), .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        exp_t   e;
        longint sa;
        longint sb;
        longint sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.r1 = '0;
        e.r2 = '0;
        e.uf = 1'b0;
        e.lat = 0;
        case (op)
            5'd1: begin sr = sa + sb; e.r1 = a + b; e.uf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            5'd2: begin sr = sa - sb; e.r1 = a - b; e.uf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
            5'd3: e.r1 = a & b;
            5'd4: e.r1 = a | b;
            5'd5: e.r1 = ~a;
            5'd6: e.r1 = a ^ b;
            5'd7: e.r1 = a << s;
            5'd8: e.r1 = a >> s;
            5'd9: e.uf = a < b;
            5'd10: e.uf = a > b;
            5'd11: e.uf = a == b;
            5'd12: e.uf = a != b;
            5'd13: e.uf = a <= b;
            5'd14: e.uf = a >= b;
            5'd15: e.r1 = {b[15:0], 16'h0};
            5'd19: e.r1 = 32'($signed(a) >>> s);
            5'd16: begin
                p = {32'h0, a} * {32'h0, b};
                e.r1 = p[31:0]; e.r2 = p[63:32]; e.uf = (p[63:32] != 0); e.lat = 33;
            end
            5'd17, 5'd18: begin
                e.uf = (b == 0);
                e.r1 = (b == 0) ? 32'hFFFF_FFFF : a / b;
                e.r2 = (b == 0) ? a : a % b;
                if (op == 5'd18) begin e.r1 = e.r2; e.r2 = (b == 0) ? 32'hFFFF_FFFF : a / b; end
                e.lat = 33;
            end
            default: e.r1 = b;
        endcase
        return e;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        chk("in_ready_before_send", 64'(in_ready), 64'd1);
        q.push_back(model(op, a, b, s));
        aluop = op; op1 = a; op2 = b; smt = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask
    task automatic collect(input string tag, input logic release_out);
        int   n = 0;
        int   bc = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_sb_nonempty"}, 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_latency"}, 64'(n), 64'(e.lat));
            chk({tag, "_busy_cycles"}, 64'(bc), (e.lat == 0) ? 64'd0 : 64'd32);
            chk({tag, "_r1"}, 64'(r1), 64'(e.r1));
            chk({tag, "_r2"}, 64'(r2), 64'(e.r2));
            chk({tag, "_uf"}, 64'(UF), 64'(e.uf));
        end
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
            chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_r1", 64'(r1), 64'd0);
        chk("rst_r2", 64'(r2), 64'd0);
        chk("rst_uf", 64'(UF), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(5'd1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        collect("add_ovf", 1'b1);
        send(5'd16, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0);
        collect("mul", 1'b1);
        send(5'd17, 32'd100, 32'd7, 5'd0);
        collect("divu", 1'b1);
        send(5'd18, 32'd100, 32'd7, 5'd0);
        collect("remu", 1'b1);
        send(5'd17, 32'h1234, 32'h0, 5'd0);
        collect("divu_by0", 1'b1);
        send(5'd18, 32'h1234, 32'h0, 5'd0);
        collect("remu_by0", 1'b1);
        send(5'd2, 32'h8000_0000, 32'h0000_0001, 5'd0);
        collect("sub_ovf", 1'b1);
        send(5'd9, 32'h5, 32'h0, 5'd0);
        collect("lt_op2_zero", 1'b1);
        send(5'd16, 32'h0001_0000, 32'h0000_FFFF, 5'd0);
        collect("mul_no_hi", 1'b1);
        for (int i = 0; i < 26; i++) begin
            send(5'(i), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom, 5'($urandom_range(0, 31)));
            collect($sformatf("rand_op%0d", i), 1'b1);
        end
        out_ready = 1'b0;
        send(5'd19, 32'h8000_0000, 32'h0, 5'd4);
        collect("sra", 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; aluop = 5'd1; op1 = 32'd1; op2 = 32'd1;
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("bp%0d_r1", i), 64'(r1), 64'hF800_0000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        send(5'd16, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_r1", 64'(r1), 64'd0);
        chk("midrst_r2", 64'(r2), 64'd0);
        chk("midrst_uf", 64'(UF), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(5'd1, 32'd3, 32'd4, 5'd0);
        collect("add_after_rst", 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ulas_seq.md
Name: ulas_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU.
- Keeps the existing 5-bit aluop encodings 00001-01111 and the default pass-through of op2.
- Adds an arithmetic right shift, an iterative unsigned multiply, and an iterative unsigned divide/remainder.
- Sits between the decode/register-read stage and writeback, with valid/ready handshakes on both sides so the pipeline stalls during multi-cycle operations.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request.
- aluop  in  5  operation select.
- op1  in  WIDTH  operand 1.
- op2  in  WIDTH  operand 2.
- smt  in  SHW  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- r1  out  WIDTH  primary result (sum, logic, shift, product low, quotient).
- r2  out  WIDTH  secondary result (product high, remainder); 0 for other ops.
- UF  out  1  flag (overflow, compare outcome, divide-by-zero).
- busy  out  1  an iterative operation is in progress.

Behaviour:
- Reset (async, any state): state=IDLE; r1=0, r2=0, UF=0, out_valid=0, busy=0, iteration counter=0; any in-flight operation is discarded.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - A request is accepted on a clock edge where in_valid && in_ready; operands and aluop are latched at that edge.
- Single-cycle ops (00001-01111, 10011, default): IDLE goes to DONE on accept. out_valid rises on that edge, so results are visible the cycle after accept.
- Iterative ops (10000, 10001, 10010): IDLE goes to BUSY on accept.
  - One shift-add or restoring-subtract step per cycle for exactly WIDTH cycles.
  - Then BUSY goes to DONE; out_valid is high WIDTH+1 edges after accept.
  - busy=1 only in BUSY.
- DONE: r1, r2, UF and out_valid are held stable until out_ready=1, then the FSM returns to IDLE and out_valid drops. in_valid is ignored outside IDLE.
- Op semantics (unsigned unless stated; r2=0 unless stated):
  - 00001 add: r1=op1+op2 mod 2^WIDTH; UF = signed overflow (operands same sign, result sign differs).
  - 00010 sub: r1=op1-op2; UF = signed overflow (operand signs differ, result sign differs from op1).
  - 00011 AND, 00100 OR, 00101 NOT op1, 00110 XOR: UF=0.
  - 00111 SLL by smt, 01000 SRL (logical) by smt: UF=0.
  - 01001-01110 compares (<, >, ==, !=, <=, >=): UF=result, r1=0.
  - 01111 load-upper: r1 = op2 << (WIDTH/2); UF=0.
  - 10011 SRA: r1 = op1 arithmetically shifted right by smt, sign-filled; UF=0.
  - 10000 MUL: {r2,r1} = op1*op2 full 2*WIDTH product; UF = (r2!=0).
  - 10001 DIVU: r1 = quotient, r2 = remainder.
  - 10010 REMU: r1 = remainder, r2 = quotient.
  - Divide by zero: r1 = all ones for DIVU / op1 for REMU; r2 = the other of the pair. UF=1, still WIDTH+1 latency.
  - Non-divide ops with op2=0 leave UF per the op rules above.
  - Other undefined codes: r1=op2, UF=0, single-cycle.
- Iteration counter is $clog2(WIDTH)+1 bits, loads 0 on accept, and terminates on reaching WIDTH-1. No wrap is possible.
- Outputs are registered; no combinational path from op1/op2 to r1/r2.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF+0x00000001, out_ready=1 → out_valid 1 cycle after accept, r1=0x80000000, UF=1; in_ready back high the next cycle.
- MUL 0xFFFFFFFF*0x00000002 → busy=1 for 32 cycles; out_valid 33 edges after accept; r1=0xFFFFFFFE, r2=0x00000001, UF=1.
- DIVU 100/7 → r1=14, r2=2, UF=0. REMU 100/7 → r1=2, r2=14.
- DIVU 0x1234/0 → r1=0xFFFFFFFF, r2=0x1234, UF=1, latency 33.
- SRA 0x80000000 by 4 → r1=0xF8000000. Backpressure: hold out_ready=0 for 5 cycles → r1 stable, out_valid=1, in_ready=0, new in_valid ignored. out_ready=1 → IDLE the next edge.
- Assert rst at cycle 10 of a MUL → all outputs 0 immediately (async), state=IDLE. After release, add 3+4 gives r1=7.
